// File: rtl/i2c_txn_sequencer.sv
// Register-level read/write sequencer driving a byte-level I2C master engine.
// Optional NACK retry is enabled by defining I2C_SEQ_RETRY_EN.
module i2c_txn_sequencer #(
    parameter int TIMEOUT_CYC = 4000000
`ifdef I2C_SEQ_RETRY_EN
    ,
    parameter int MAX_RETRY = 3
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       eng_go,
    output logic       eng_start,
    output logic       eng_stop,
    output logic       eng_rw,
    output logic [7:0] eng_dataW,
    input  logic       eng_ack,
    input  logic       eng_nack,
    input  logic       eng_to,
    input  logic [7:0] eng_dataR
);

    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_W, S_REG, S_WDATA,
        S_RSTART, S_RDATA, S_STOP, S_RESP
    } state_t;

    state_t state_q, state_d, nxt;
    logic           rw_q, rw_d;
    logic [6:0]     addr_q, addr_d;
    logic [7:0]     reg_q, reg_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           req_ready_q, req_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]     rsp_err_q, rsp_err_d;
    logic           eng_go_q, eng_go_d;
    logic           eng_start_q, eng_start_d;
    logic           eng_stop_q, eng_stop_d;
    logic           eng_rw_q, eng_rw_d;
    logic [7:0]     eng_dataW_q, eng_dataW_d;
    logic           enter;
    logic           expired;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTW-1:0] retry_q, retry_d;
`endif

    assign expired = (wd_q == WDW'(TIMEOUT_CYC));

    always_comb begin
        case (state_q)
            S_ADDR_W: nxt = S_REG;
            S_REG:    nxt = rw_q ? S_RSTART : S_WDATA;
            S_RSTART: nxt = S_RDATA;
            default:  nxt = S_STOP;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        wd_d        = wd_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        eng_go_d    = 1'b0;
        eng_start_d = eng_start_q;
        eng_stop_d  = eng_stop_q;
        eng_rw_d    = eng_rw_q;
        eng_dataW_d = eng_dataW_q;
        enter       = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    rw_d        = req_rw;
                    addr_d      = req_addr;
                    reg_d       = req_reg;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = '0;
                    state_d     = S_ADDR_W;
                    enter       = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
                    retry_d     = '0;
`endif
                end
            end
            S_ADDR_W, S_REG, S_WDATA, S_RSTART, S_RDATA: begin
                if (!eng_go_q) begin
                    wd_d = wd_q + WDW'(1);
                    if (eng_to || expired) begin
                        rsp_err_d = 2'b10;
                        state_d   = S_STOP;
                        enter     = 1'b1;
                    end else if (eng_nack) begin
                        rsp_err_d = 2'b01;
                        state_d   = S_STOP;
                        enter     = 1'b1;
                    end else if (eng_ack) begin
                        if (state_q == S_RDATA) rsp_rdata_d = eng_dataR;
                        state_d = nxt;
                        enter   = 1'b1;
                    end
                end
            end
            S_STOP: begin
                // Stop-phase faults never overwrite the transaction's error.
                if (!eng_go_q) begin
                    wd_d = wd_q + WDW'(1);
                    if (eng_ack || expired) begin
                        eng_start_d = 1'b0;
                        eng_stop_d  = 1'b0;
                        eng_rw_d    = 1'b0;
                        eng_dataW_d = '0;
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
                        if (rsp_err_q == 2'b01 &&
                            retry_q < RTW'(MAX_RETRY)) begin
                            retry_d     = retry_q + RTW'(1);
                            rsp_err_d   = '0;
                            rsp_valid_d = 1'b0;
                            state_d     = S_ADDR_W;
                            enter       = 1'b1;
                        end
`endif
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = '0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter) begin
            eng_go_d    = 1'b1;
            wd_d        = '0;
            eng_start_d = 1'b0;
            eng_stop_d  = 1'b0;
            eng_rw_d    = 1'b0;
            eng_dataW_d = '0;
            case (state_d)
                S_ADDR_W: begin
                    eng_start_d = 1'b1;
                    eng_dataW_d = {addr_d, 1'b0};
                end
                S_REG:   eng_dataW_d = reg_d;
                S_WDATA: eng_dataW_d = wdata_d;
                S_RSTART: begin
                    eng_start_d = 1'b1;
                    eng_dataW_d = {addr_d, 1'b1};
                end
                S_RDATA: eng_rw_d   = 1'b1;
                S_STOP:  eng_stop_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            wd_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
            eng_go_q    <= 1'b0;
            eng_start_q <= 1'b0;
            eng_stop_q  <= 1'b0;
            eng_rw_q    <= 1'b0;
            eng_dataW_q <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            wd_q        <= wd_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            eng_go_q    <= eng_go_d;
            eng_start_q <= eng_start_d;
            eng_stop_q  <= eng_stop_d;
            eng_rw_q    <= eng_rw_d;
            eng_dataW_q <= eng_dataW_d;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign eng_go    = eng_go_q;
    assign eng_start = eng_start_q;
    assign eng_stop  = eng_stop_q;
    assign eng_rw    = eng_rw_q;
    assign eng_dataW = eng_dataW_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a scripted byte-engine responder.
// Expected values follow the I2C_SEQ_RETRY_EN setting of the build.
module tb_i2c_txn_sequencer;

    localparam int TO_CYC = 100;
`ifdef I2C_SEQ_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif
    localparam int R_ACK = 0, R_NACK = 1, R_TO = 2, R_TONACK = 3, R_NONE = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_reg = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       eng_go, eng_start, eng_stop, eng_rw;
    logic [7:0] eng_dataW;
    logic       eng_ack = 1'b0;
    logic       eng_nack = 1'b0;
    logic       eng_to = 1'b0;
    logic [7:0] eng_dataR = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    i2c_txn_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .eng_go(eng_go), .eng_start(eng_start),
        .eng_stop(eng_stop), .eng_rw(eng_rw),
        .eng_dataW(eng_dataW), .eng_ack(eng_ack),
        .eng_nack(eng_nack), .eng_to(eng_to),
        .eng_dataR(eng_dataR)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk(tag, {req_ready, rsp_valid, rsp_rdata, rsp_err, eng_go,
                  eng_start, eng_stop, eng_rw, eng_dataW}, 32'h0);
    endtask

    task automatic send_req(input logic rw, input logic [6:0] addr,
                            input logic [7:0] rg, input logic [7:0] wd);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_rw = rw;
        req_addr = addr;
        req_reg = rg;
        req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        chk("req_ready_drop", req_ready, 0);
    endtask

    // ctl = {start, stop, rw}
    task automatic byte_op(input string tag, input logic [2:0] ctl,
                           input logic cd, input logic [7:0] data,
                           input int resp, input logic [7:0] rd,
                           output int go_cyc);
        int n = 0;
        while (!eng_go && n < 3 * TO_CYC) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_go"}, eng_go, 1);
        go_cyc = cyc;
        chk({tag, "_ctl"}, {eng_start, eng_stop, eng_rw}, ctl);
        if (cd) chk({tag, "_data"}, eng_dataW, data);
        @(negedge clock);
        if (resp != R_NONE) begin
            eng_ack   = (resp == R_ACK);
            eng_nack  = (resp == R_NACK || resp == R_TONACK);
            eng_to    = (resp == R_TO || resp == R_TONACK);
            eng_dataR = rd;
            if (cd) chk({tag, "_hold"}, eng_dataW, data);
            @(negedge clock);
            eng_ack  = 1'b0;
            eng_nack = 1'b0;
            eng_to   = 1'b0;
        end
    endtask

    task automatic get_rsp(input string tag, input logic [7:0] rd,
                           input logic [1:0] err, input int hold);
        int n = 0;
        while (!rsp_valid && n < 3 * TO_CYC) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_rdata"}, rsp_rdata, rd);
        chk({tag, "_err"}, rsp_err, err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, "_held"}, {rsp_valid, rsp_rdata, rsp_err},
                {1'b1, rd, err});
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, rsp_valid, 0);
    endtask

    initial begin
        int c0, c1, c2;
        repeat (3) @(negedge clock);
        all_zero("reset_outputs");
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", req_ready, 1);

        // register write, all bytes ACKed
        send_req(1'b0, 7'h50, 8'h10, 8'hA5);
        byte_op("w_addr", 3'b100, 1, 8'hA0, R_ACK, 8'h00, c0);
        byte_op("w_reg", 3'b000, 1, 8'h10, R_ACK, 8'h00, c1);
        chk("go_to_go_latency", c1 - c0, 2);
        byte_op("w_data", 3'b000, 1, 8'hA5, R_ACK, 8'h00, c2);
        byte_op("w_stop", 3'b010, 0, 8'h00, R_ACK, 8'h00, c2);
        get_rsp("w_rsp", 8'h00, 2'b00, 0);
        chk("ready_after_rsp", req_ready, 1);

        // register read returning 0x3C
        send_req(1'b1, 7'h50, 8'h02, 8'hFF);
        byte_op("r_addr", 3'b100, 1, 8'hA0, R_ACK, 8'h00, c0);
        byte_op("r_reg", 3'b000, 1, 8'h02, R_ACK, 8'h00, c0);
        byte_op("r_rstart", 3'b100, 1, 8'hA1, R_ACK, 8'h00, c0);
        byte_op("r_rdata", 3'b001, 0, 8'h00, R_ACK, 8'h3C, c0);
        byte_op("r_stop", 3'b010, 0, 8'h00, R_ACK, 8'h00, c0);
        get_rsp("r_rsp", 8'h3C, 2'b00, 0);

        // address NACK: stop follows directly, retried when enabled
        send_req(1'b0, 7'h50, 8'h10, 8'h11);
        for (int a = 0; a < ATTEMPTS; a++) begin
            byte_op("n_addr", 3'b100, 1, 8'hA0, R_NACK, 8'h00, c0);
            byte_op("n_stop", 3'b010, 0, 8'h00, R_ACK, 8'h00, c0);
        end
        get_rsp("n_rsp", 8'h00, 2'b01, 0);

        // silent engine on REG byte: local watchdog fires
        send_req(1'b0, 7'h50, 8'h20, 8'h22);
        byte_op("t_addr", 3'b100, 1, 8'hA0, R_ACK, 8'h00, c0);
        byte_op("t_reg", 3'b000, 1, 8'h20, R_NONE, 8'h00, c1);
        byte_op("t_stop", 3'b010, 0, 8'h00, R_ACK, 8'h00, c2);
        chk("t_wait_min", (c2 - c1) >= TO_CYC, 1);
        chk("t_wait_max", (c2 - c1) <= TO_CYC + 3, 1);
        get_rsp("t_rsp", 8'h00, 2'b10, 0);

        // TO and NACK together; silent stop; response back-pressured
        send_req(1'b0, 7'h50, 8'h30, 8'h33);
        byte_op("tn_addr", 3'b100, 1, 8'hA0, R_TONACK, 8'h00, c0);
        byte_op("tn_stop", 3'b010, 0, 8'h00, R_NONE, 8'h00, c0);
        get_rsp("tn_rsp", 8'h00, 2'b10, 5);

        // reset while waiting on the read data byte
        send_req(1'b1, 7'h50, 8'h04, 8'h00);
        byte_op("x_addr", 3'b100, 1, 8'hA0, R_ACK, 8'h00, c0);
        byte_op("x_reg", 3'b000, 1, 8'h04, R_ACK, 8'h00, c0);
        byte_op("x_rstart", 3'b100, 1, 8'hA1, R_ACK, 8'h00, c0);
        byte_op("x_rdata", 3'b001, 0, 8'h00, R_NONE, 8'h00, c0);
        reset = 1'b1;
        @(negedge clock);
        all_zero("x_reset_outputs");
        reset = 1'b0;
        @(negedge clock);
        chk("x_ready_after_reset", req_ready, 1);
        chk("x_no_go", eng_go, 0);
        send_req(1'b0, 7'h2A, 8'h7E, 8'h5A);
        byte_op("y_addr", 3'b100, 1, 8'h54, R_ACK, 8'h00, c0);
        byte_op("y_reg", 3'b000, 1, 8'h7E, R_ACK, 8'h00, c0);
        byte_op("y_data", 3'b000, 1, 8'h5A, R_ACK, 8'h00, c0);
        byte_op("y_stop", 3'b010, 0, 8'h00, R_ACK, 8'h00, c0);
        get_rsp("y_rsp", 8'h00, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
